max_track_ctrl: RTL

- Sequencer for the max-score register bank of the local-alignment datapath.
- Per alignment job it does three things:
  - clears the bank with a one-cycle start pulse;
  - gates wr_en_max while the PE array delivers score blocks, and counts them;
  - waits one settle cycle after the final block, then captures score/row/col into a result buffer and presents it to the top controller over a valid/ready handshake.

---
 rtl/design_variables_pkg.sv | 26 ++
 rtl/max_reg_bank.sv | 34 +++
 rtl/max_track_top.sv | 63 ++++++
 rtl/max_track_ctrl.sv | 90 +++++++++
 4 files changed

// File: rtl/design_variables_pkg.sv
// Shared widths and types for the local-alignment datapath, including the
// max-score tracking controller state and result buffer layout.
package design_variables;

  localparam int unsigned SCORE_WIDTH    = 16;
  localparam int unsigned ROW_BITS_WIDTH = 10;
  localparam int unsigned COL_BITS_WIDTH = 10;

  localparam int unsigned MAX_BLOCKS    = 1024;
  localparam int unsigned BLK_CNT_WIDTH = $clog2(MAX_BLOCKS + 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    SETTLE,
    HOLD
  } max_ctrl_state_t;

  typedef struct packed {
    logic [SCORE_WIDTH-1:0]    score;
    logic [ROW_BITS_WIDTH-1:0] row;
    logic [COL_BITS_WIDTH-1:0] col;
  } max_result_t;

endpackage

// File: rtl/max_reg_bank.sv
// Max-score register bank: tracks the highest score seen since the last start
// pulse together with its row/column.
module max_reg_bank
  import design_variables::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      wr_en_max,
  input  logic [SCORE_WIDTH-1:0]    in_score,
  input  logic [ROW_BITS_WIDTH-1:0] in_row,
  input  logic [COL_BITS_WIDTH-1:0] in_col,
  output logic [SCORE_WIDTH-1:0]    max_score,
  output logic [ROW_BITS_WIDTH-1:0] max_row,
  output logic [COL_BITS_WIDTH-1:0] max_col
);

  max_result_t max_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= '0;
    end else if (start) begin
      max_q <= '0;
    end else if (wr_en_max && (in_score > max_q.score)) begin
      max_q <= '{score: in_score, row: in_row, col: in_col};
    end
  end

  assign max_score = max_q.score;
  assign max_row   = max_q.row;
  assign max_col   = max_q.col;

endmodule

// File: rtl/max_track_top.sv
// Integration wrapper: ties the tracking controller to the max register bank.
module max_track_top
  import design_variables::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      job_start,
  input  logic [BLK_CNT_WIDTH-1:0]  cfg_num_blocks,
  input  logic                      abort,
  input  logic                      blk_valid,
  output logic                      blk_ready,
  input  logic [SCORE_WIDTH-1:0]    pe_score,
  input  logic [ROW_BITS_WIDTH-1:0] pe_row,
  input  logic [COL_BITS_WIDTH-1:0] pe_col,
  output logic                      busy,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [SCORE_WIDTH-1:0]    res_score,
  output logic [ROW_BITS_WIDTH-1:0] res_row,
  output logic [COL_BITS_WIDTH-1:0] res_col
);

  logic                      start;
  logic                      wr_en_max;
  logic [SCORE_WIDTH-1:0]    max_score;
  logic [ROW_BITS_WIDTH-1:0] max_row;
  logic [COL_BITS_WIDTH-1:0] max_col;

  max_reg_bank u_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .wr_en_max (wr_en_max),
    .in_score  (pe_score),
    .in_row    (pe_row),
    .in_col    (pe_col),
    .max_score (max_score),
    .max_row   (max_row),
    .max_col   (max_col)
  );

  max_track_ctrl u_ctrl (
    .clk            (clk),
    .rst_n          (rst_n),
    .job_start      (job_start),
    .cfg_num_blocks (cfg_num_blocks),
    .abort          (abort),
    .blk_valid      (blk_valid),
    .blk_ready      (blk_ready),
    .start          (start),
    .wr_en_max      (wr_en_max),
    .max_score      (max_score),
    .max_row        (max_row),
    .max_col        (max_col),
    .busy           (busy),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_score      (res_score),
    .res_row        (res_row),
    .res_col        (res_col)
  );

endmodule

// File: rtl/max_track_ctrl.sv
// Sequencer for the max-score bank: clears it per job, gates block updates,
// then captures the final max into a valid/ready result buffer.
module max_track_ctrl
  import design_variables::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      job_start,
  input  logic [BLK_CNT_WIDTH-1:0]  cfg_num_blocks,
  input  logic                      abort,
  input  logic                      blk_valid,
  output logic                      blk_ready,
  output logic                      start,
  output logic                      wr_en_max,
  input  logic [SCORE_WIDTH-1:0]    max_score,
  input  logic [ROW_BITS_WIDTH-1:0] max_row,
  input  logic [COL_BITS_WIDTH-1:0] max_col,
  output logic                      busy,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [SCORE_WIDTH-1:0]    res_score,
  output logic [ROW_BITS_WIDTH-1:0] res_row,
  output logic [COL_BITS_WIDTH-1:0] res_col
);

  localparam logic [BLK_CNT_WIDTH-1:0] MaxBlocks = BLK_CNT_WIDTH'(MAX_BLOCKS);
  localparam logic [BLK_CNT_WIDTH-1:0] CntOne    = BLK_CNT_WIDTH'(1);

  max_ctrl_state_t          state_q;
  logic [BLK_CNT_WIDTH-1:0] cnt_q;
  logic [BLK_CNT_WIDTH-1:0] num_q;
  max_result_t              res_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      num_q   <= '0;
      res_q   <= '0;
    end else if (abort && (state_q != IDLE)) begin
      // Result buffer deliberately untouched so the last good result survives.
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (job_start) begin
            num_q   <= (cfg_num_blocks > MaxBlocks) ? MaxBlocks : cfg_num_blocks;
            cnt_q   <= '0;
            state_q <= CLEAR;
          end
        end
        CLEAR: begin
          state_q <= (num_q == '0) ? SETTLE : ACCUM;
        end
        ACCUM: begin
          if (blk_valid) begin
            cnt_q <= cnt_q + CntOne;
            if (cnt_q == (num_q - CntOne)) begin
              state_q <= SETTLE;
            end
          end
        end
        SETTLE: begin
          // Bank has absorbed the final update by now; safe to sample.
          res_q   <= '{score: max_score, row: max_row, col: max_col};
          state_q <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign start     = (state_q == CLEAR);
  assign blk_ready = (state_q == ACCUM);
  assign wr_en_max = (state_q == ACCUM) && blk_valid;
  assign busy      = (state_q != IDLE);
  assign res_valid = (state_q == HOLD);
  assign res_score = res_q.score;
  assign res_row   = res_q.row;
  assign res_col   = res_q.col;

endmodule
